// File: rtl/midi_msg_decoder.sv
// MIDI channel-message decoder: parses a resynchronised UART byte stream with running
// status and emits registered one-cycle event pulses plus held note/controller fields.
module midi_msg_decoder #(
  parameter logic [6:0] RESET_CC = 7'd121
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       valid_byte,
  input  logic [7:0] data,
  output logic       note_pressed,
  output logic       note_released,
  output logic       note_keypress,
  output logic       cc_update,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic [3:0] channel,
  output logic [7:0] addr,
  output logic       rst_cmd
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    IGNORE  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] kind, kind_nxt;
  logic [3:0] chan, chan_nxt;
  logic [6:0] d1, d1_nxt;

  logic       pressed_nxt, released_nxt, keypress_nxt, cc_nxt, rst_nxt;
  logic [6:0] note_nxt, velocity_nxt;
  logic [3:0] channel_nxt;
  logic [7:0] addr_nxt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state         <= IDLE;
      kind          <= 4'd0;
      chan          <= 4'd0;
      d1            <= 7'd0;
      note_pressed  <= 1'b0;
      note_released <= 1'b0;
      note_keypress <= 1'b0;
      cc_update     <= 1'b0;
      rst_cmd       <= 1'b0;
      note          <= 7'd0;
      velocity      <= 7'd0;
      channel       <= 4'd0;
      addr          <= 8'd0;
    end else begin
      state         <= state_nxt;
      kind          <= kind_nxt;
      chan          <= chan_nxt;
      d1            <= d1_nxt;
      note_pressed  <= pressed_nxt;
      note_released <= released_nxt;
      note_keypress <= keypress_nxt;
      cc_update     <= cc_nxt;
      rst_cmd       <= rst_nxt;
      note          <= note_nxt;
      velocity      <= velocity_nxt;
      channel       <= channel_nxt;
      addr          <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    kind_nxt     = kind;
    chan_nxt     = chan;
    d1_nxt       = d1;
    pressed_nxt  = 1'b0;
    released_nxt = 1'b0;
    keypress_nxt = 1'b0;
    cc_nxt       = 1'b0;
    rst_nxt      = 1'b0;
    note_nxt     = note;
    velocity_nxt = velocity;
    channel_nxt  = channel;
    addr_nxt     = addr;

    if (valid_byte) begin
      if (data[7]) begin
        if (data == 8'hFF) begin
          rst_nxt   = 1'b1;
          state_nxt = IDLE;
          kind_nxt  = 4'd0;
          chan_nxt  = 4'd0;
        end else if (data >= 8'hF8) begin
          // Realtime bytes pass through without disturbing a message in flight.
          state_nxt = state;
        end else if (data >= 8'hF0) begin
          state_nxt = IGNORE;
          kind_nxt  = 4'd0;
          chan_nxt  = 4'd0;
        end else begin
          state_nxt = WAIT_D1;
          kind_nxt  = data[7:4];
          chan_nxt  = data[3:0];
        end
      end else begin
        case (state)
          WAIT_D1: begin
            d1_nxt = data[6:0];
            // Program change and channel pressure finish on one byte and are dropped.
            if (kind == 4'hC || kind == 4'hD) begin
              state_nxt = WAIT_D1;
            end else begin
              state_nxt = WAIT_D2;
            end
          end
          WAIT_D2: begin
            state_nxt = WAIT_D1;
            case (kind)
              4'h8: begin
                released_nxt = 1'b1;
                note_nxt     = d1;
                velocity_nxt = data[6:0];
                channel_nxt  = chan;
              end
              4'h9: begin
                if (data[6:0] != 7'd0) begin
                  pressed_nxt = 1'b1;
                end else begin
                  released_nxt = 1'b1;
                end
                note_nxt     = d1;
                velocity_nxt = data[6:0];
                channel_nxt  = chan;
              end
              4'hA: begin
                keypress_nxt = 1'b1;
                note_nxt     = d1;
                velocity_nxt = data[6:0];
                channel_nxt  = chan;
              end
              4'hB: begin
                cc_nxt       = 1'b1;
                addr_nxt     = {1'b0, d1};
                velocity_nxt = data[6:0];
                channel_nxt  = chan;
                rst_nxt      = (d1 == RESET_CC);
              end
              default: begin
                state_nxt = WAIT_D1;
              end
            endcase
          end
          default: begin
            state_nxt = state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_decoder.sv
// Bench for midi_msg_decoder: directed MIDI sequences plus random byte streams, all
// checked against a byte-queue reference model of the MIDI running-status rules.
module tb_midi_msg_decoder;

  logic       clk = 1'b0;
  logic       nreset;
  logic       valid_byte;
  logic [7:0] data;
  logic       note_pressed, note_released, note_keypress, cc_update, rst_cmd;
  logic [6:0] note, velocity;
  logic [3:0] channel;
  logic [7:0] addr;

  int n_vectors = 0;
  int n_miscompares = 0;

  logic [7:0] run_status;
  logic [6:0] pend[$];
  logic       e_pressed, e_released, e_keypress, e_cc, e_rst;
  logic [6:0] e_note, e_velocity;
  logic [3:0] e_channel;
  logic [7:0] e_addr;

  midi_msg_decoder dut (
    .clk(clk),
    .nreset(nreset),
    .valid_byte(valid_byte),
    .data(data),
    .note_pressed(note_pressed),
    .note_released(note_released),
    .note_keypress(note_keypress),
    .cc_update(cc_update),
    .note(note),
    .velocity(velocity),
    .channel(channel),
    .addr(addr),
    .rst_cmd(rst_cmd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vectors++;
    assert (obs === exp) else begin
      n_miscompares++;
      $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    run_status = 8'h00;
    pend.delete();
    {e_pressed, e_released, e_keypress, e_cc, e_rst} = 5'b0;
    e_note = 7'd0;
    e_velocity = 7'd0;
    e_channel = 4'd0;
    e_addr = 8'd0;
  endtask

  // Expected results for a byte; visible one clock after it is presented.
  task automatic model_update(input logic v, input logic [7:0] b);
    int hi;
    int need;
    logic [6:0] a1, a2;
    {e_pressed, e_released, e_keypress, e_cc, e_rst} = 5'b0;
    if (!v) return;
    if (b == 8'hFF) begin
      e_rst = 1'b1;
      run_status = 8'h00;
      pend.delete();
    end else if (b >= 8'hF8) begin
      return;
    end else if (b >= 8'hF0) begin
      run_status = 8'h00;
      pend.delete();
    end else if (b >= 8'h80) begin
      run_status = b;
      pend.delete();
    end else if (run_status != 8'h00) begin
      hi = int'(run_status) / 16;
      need = (hi == 12 || hi == 13) ? 1 : 2;
      pend.push_back(b[6:0]);
      if (pend.size() == need) begin
        a1 = pend[0];
        a2 = (need == 2) ? pend[1] : 7'd0;
        pend.delete();
        case (hi)
          8:  begin e_released = 1'b1; e_note = a1; e_velocity = a2; e_channel = run_status[3:0]; end
          9:  begin
                if (a2 != 0) e_pressed = 1'b1; else e_released = 1'b1;
                e_note = a1; e_velocity = a2; e_channel = run_status[3:0];
              end
          10: begin e_keypress = 1'b1; e_note = a1; e_velocity = a2; e_channel = run_status[3:0]; end
          11: begin
                e_cc = 1'b1; e_addr = {1'b0, a1}; e_velocity = a2; e_channel = run_status[3:0];
                e_rst = (a1 == 7'd121);
              end
          default: ;
        endcase
      end
    end
  endtask

  task automatic checkOutput();
    chk("note_pressed", {7'd0, note_pressed}, {7'd0, e_pressed});
    chk("note_released", {7'd0, note_released}, {7'd0, e_released});
    chk("note_keypress", {7'd0, note_keypress}, {7'd0, e_keypress});
    chk("cc_update", {7'd0, cc_update}, {7'd0, e_cc});
    chk("rst_cmd", {7'd0, rst_cmd}, {7'd0, e_rst});
    chk("note", {1'b0, note}, {1'b0, e_note});
    chk("velocity", {1'b0, velocity}, {1'b0, e_velocity});
    chk("channel", {4'd0, channel}, {4'd0, e_channel});
    chk("addr", addr, e_addr);
  endtask

  // One clock: check the previous byte's results, then present the next input.
  task automatic applyStimulus(input logic v, input logic [7:0] b);
    @(negedge clk);
    checkOutput();
    valid_byte = v;
    data = b;
    model_update(v, b);
  endtask

  task automatic send(input logic [7:0] b);
    applyStimulus(1'b1, b);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'h00);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    checkOutput();
    valid_byte = 1'b0;
    data = 8'h00;
    nreset = 1'b0;
    model_reset();
    #2;
    chk("rst_outputs", {3'd0, note_pressed, note_released, note_keypress, cc_update, rst_cmd}, 8'h00);
    chk("rst_fields", {1'b0, note} | {1'b0, velocity} | {4'd0, channel} | addr, 8'h00);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    nreset = 1'b0;
    valid_byte = 1'b0;
    data = 8'h00;
    model_reset();
    #2;
    chk("init_rst_outputs", {3'd0, note_pressed, note_released, note_keypress, cc_update, rst_cmd}, 8'h00);
    chk("init_rst_fields", {1'b0, note} | {1'b0, velocity} | {4'd0, channel} | addr, 8'h00);
    @(negedge clk);
    nreset = 1'b1;
    idle();

    send(8'h93); send(8'h3C); send(8'h64); idle();
    chk("tp_noteon_pulse", {7'd0, note_pressed}, 8'h01);
    chk("tp_noteon_note", {1'b0, note}, 8'h3C);
    chk("tp_noteon_chan", {4'd0, channel}, 8'h03);
    idle();

    send(8'h90); send(8'h40); send(8'h10); send(8'h40); send(8'h00); idle();
    chk("tp_running_release", {7'd0, note_released}, 8'h01);
    chk("tp_running_vel", {1'b0, velocity}, 8'h00);

    send(8'h8F); send(8'h30); send(8'h7F); idle();
    chk("tp_noteoff_chan", {4'd0, channel}, 8'h0F);
    send(8'hA1); send(8'h30); send(8'h22); idle();
    chk("tp_keypress", {7'd0, note_keypress}, 8'h01);

    send(8'h92); send(8'h45); send(8'hF8); send(8'h50); idle();
    chk("tp_realtime_vel", {1'b0, velocity}, 8'h50);

    send(8'hB0); send(8'h07); send(8'h55); idle();
    chk("tp_cc_addr", addr, 8'h07);
    send(8'hB0); send(8'h79); send(8'h00); idle();
    chk("tp_cc_reset", {6'd0, cc_update, rst_cmd}, 8'h03);
    send(8'hFF); idle();
    chk("tp_sysreset", {6'd0, cc_update, rst_cmd}, 8'h01);

    send(8'hC0); send(8'h05); idle();
    send(8'hF0); send(8'h11); send(8'h22); send(8'hF7); send(8'h33); idle();
    send(8'h90); send(8'h3C);
    reset_dut();
    send(8'h64); idle(); idle();
    chk("tp_after_reset", {7'd0, note_pressed}, 8'h00);

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] b;
      int sel;
      sel = $urandom_range(0, 19);
      if (sel < 4) b = 8'(8'h80 + $urandom_range(0, 8'h6F));
      else if (sel == 4) b = 8'(8'hF8 + $urandom_range(0, 7));
      else if (sel == 5) b = 8'(8'hF0 + $urandom_range(0, 7));
      else if (sel == 6) b = 8'hB0 | 8'($urandom_range(0, 15));
      else if (sel == 7) b = 8'd121;
      else b = 8'($urandom_range(0, 127));
      applyStimulus(($urandom_range(0, 9) < 8), b);
      if (i % 1000 == 999) reset_dut();
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/midi_msg_decoder.md
Name: midi_msg_decoder

Overview:
- Byte-level MIDI channel-message decoder in the clk32 synthesis domain.
- Consumes resynchronised UART bytes (one-cycle valid strobes) and tracks MIDI status and running status.
- Emits one-cycle event pulses plus held note, velocity, channel, controller and value fields to the voice engine.
- Also issues a one-cycle reset-command pulse to the top-level reset generator.

Parameters:
- RESET_CC, 121, controller number whose Control Change raises rst_cmd.

Ports:
- clk  input  1  system clock (clk32); all logic rises on posedge.
- nreset  input  1  asynchronous, active-low reset.
- valid_byte  input  1  one-cycle strobe; data is valid this cycle.
- data  input  8  received MIDI byte.
- note_pressed  output  1  one-cycle pulse: note-on with velocity ≠ 0.
- note_released  output  1  one-cycle pulse: note-off, or note-on with velocity 0.
- note_keypress  output  1  one-cycle pulse: polyphonic aftertouch.
- cc_update  output  1  one-cycle pulse: Control Change received.
- note  output  7  note number of the last note/aftertouch event.
- velocity  output  7  velocity, pressure or controller value of the last event.
- channel  output  4  channel of the last completed event.
- addr  output  8  {1'b0, controller number} of the last Control Change.
- rst_cmd  output  1  one-cycle reset-command pulse.

Behaviour:
- Reset: nreset low clears all outputs and internal state to 0 asynchronously. Parser returns to IDLE with no running status.
- Byte processing: bytes are examined only when valid_byte = 1. Cycles without valid_byte change nothing except clearing pulses.
- Pulse outputs are registered:
  - asserted exactly in the cycle after the valid_byte cycle that completes a message;
  - high for exactly one cycle;
  - never more than one event pulse per message.
- Field update: note, velocity, channel and addr update in the same cycle their pulse rises, then hold until the next qualifying event.
- Status byte 0x80–0xEF:
  - latches status type and channel (low nibble) as running status;
  - discards any partial message;
  - state becomes WAIT_D1.
- Data bytes per status type:
  - 8n, 9n, An, Bn, En take two data bytes;
  - Cn, Dn take one data byte.
- WAIT_D1 + data byte (bit7 = 0):
  - stores d1;
  - goes to WAIT_D2, or completes the message for one-byte types.
- WAIT_D2 + data byte: completes the message, then returns to WAIT_D1 with running status retained. Further data pairs therefore decode under the same status.
- Completion actions:
  - 8n: note_released; note = d1, velocity = d2.
  - 9n with d2 ≠ 0: note_pressed; note = d1, velocity = d2.
  - 9n with d2 = 0: note_released; note = d1, velocity = 0.
  - An: note_keypress; note = d1, velocity = d2.
  - Bn: cc_update; addr = {0, d1}, velocity = d2. If d1 == RESET_CC, rst_cmd also pulses.
  - Cn, Dn, En: consumed silently; no pulse, no field change.
- channel is written with the latched channel on every pulse-producing completion.
- System common 0xF0–0xF7:
  - clears running status;
  - state becomes IGNORE;
  - data bytes are dropped until the next channel status byte.
- Realtime bytes 0xF8–0xFF are transparent: no change to state or partial data. Exception: 0xFF (System Reset) pulses rst_cmd and also clears running status to IDLE.
- Data byte in IDLE or IGNORE: dropped.
- rst_cmd and an event pulse may be high in the same cycle only for Bn with d1 = RESET_CC (rst_cmd together with cc_update).
- Back-to-back valid_byte on consecutive cycles must be accepted. Required throughput is one byte per clock.

Test Plan:
- Note-on 0x93,0x3C,0x64 → one cycle after the last byte: note_pressed = 1 for 1 cycle; note = 0x3C, velocity = 0x64, channel = 3.
- Running status 0x90,0x40,0x10,0x40,0x00 → note_pressed (note 0x40, velocity 0x10), then note_released (note 0x40, velocity 0), channel = 0.
- Note-off 0x8F,0x30,0x7F → note_released; note = 0x30, velocity = 0x7F, channel = 15. Then aftertouch 0xA1,0x30,0x22 → note_keypress, velocity = 0x22, channel = 1.
- Realtime 0xF8 inserted between the two data bytes of 0x92,0x45,0xF8,0x50 → single note_pressed; note = 0x45, velocity = 0x50.
- Control changes:
  - 0xB0,0x07,0x55 → cc_update, addr = 0x07, velocity = 0x55, no rst_cmd.
  - 0xB0,0x79,0x00 → cc_update and rst_cmd together for 1 cycle.
  - Lone 0xFF → rst_cmd only.
- Ignore paths:
  - 0xC0,0x05 → no pulses.
  - 0xF0,0x11,0x22,0xF7,0x33 → no pulses.
  - nreset asserted mid-message after 0x90,0x3C, then 0x64 → no pulse.
  - All outputs read 0 during reset.
